// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
// Purely declarative: no logic, no latency, no flow control.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after i_last_grant, wrapping around.
// Purely combinational, zero latency; holds nothing and applies no backpressure.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin share of one APB master among NUM_REQ requesters, with wait-state timeout.
// Accept->rsp_valid is 3 cycles plus wait states; req_ready pulses only in IDLE, so requesters stall while a transfer is in flight.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [IDX_W-1:0]     r_last_grant;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_psel;
  logic                 r_penable;
  logic [ADDR_W-1:0]    r_paddr;
  logic                 r_pwrite;
  logic [DATA_W-1:0]    r_pwdata;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 r_rsp_slverr;
  logic                 r_rsp_timeout;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_to_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_next_state = SETUP;
      SETUP:               w_next_state = ACCESS;
      ACCESS:  if (w_done) w_next_state = IDLE;
      default:             w_next_state = IDLE;
    endcase
  end

  // Timeout fires on the last allowed ACCESS cycle, so a hung slave sees exactly TIMEOUT_CYC of them.
  always_comb begin
    req_ready = '0;
    w_accept  = 1'b0;
    w_to_hit  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready = w_grant;
          w_accept  = 1'b1;
        end
      end
      ACCESS: begin
        w_to_hit = TO_EN && !pready && (r_cnt == TO_LAST);
        w_done   = pready || w_to_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_paddr      <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
        r_pwrite     <= req_write[w_grant_idx];
        r_pwdata     <= req_wdata[w_grant_idx*DATA_W +: DATA_W];
        r_psel       <= 1'b1;
        r_last_grant <= w_grant_idx;
        r_cnt        <= '0;
      end
      if (r_state == SETUP) r_penable <= 1'b1;
      if (r_state == ACCESS) begin
        if (w_done) begin
          r_psel        <= 1'b0;
          r_penable     <= 1'b0;
          r_rsp_valid   <= NUM_REQ'(1) << r_last_grant;
          r_rsp_rdata   <= (w_to_hit || r_pwrite) ? '0 : prdata;
          r_rsp_slverr  <= w_to_hit | pslverr;
          r_rsp_timeout <= w_to_hit;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_apb_master_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                      aclk = 1'b0;
  logic                      aresetn = 1'b0;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;
  logic                      psel;
  logic                      penable;
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  int total = 0;
  int bad   = 0;

  // Slave behaviour for the current transfer, set by the tests.
  int                s_waits = 0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              s_err   = 1'b0;
  int                s_cnt   = 0;

  always #5 aclk = ~aclk;

  apb_master_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // APB slave: inserts s_waits wait states, then answers with s_rdata/s_err.
  initial begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    forever begin
      @(posedge aclk);
      #2;
      if (psel && penable) begin
        pready  = (s_cnt >= s_waits);
        prdata  = s_rdata;
        pslverr = s_err;
        s_cnt++;
      end else begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        s_cnt   = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic w, input logic [DATA_W-1:0] d);
    req_valid[i]                 = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_write[i]                 = w;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic test_reset;
    req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    aresetn = 1'b0;
    tick;
    #2;
    total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got psel/penable/pwrite=%b want 000", {psel, penable, pwrite}); end
    total++; if (paddr !== '0) begin bad++; $display("FAIL reset_paddr: got %h want 0", paddr); end
    total++; if (pwdata !== '0) begin bad++; $display("FAIL reset_pwdata: got %h want 0", pwdata); end
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if ({rsp_rdata, rsp_slverr, rsp_timeout} !== '0) begin bad++; $display("FAIL reset_rsp_fields: got rdata=%h err=%b to=%b want 0", rsp_rdata, rsp_slverr, rsp_timeout); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_write_basic;
    tick;
    set_req(0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF);
    s_waits = 0; s_err = 1'b0; s_rdata = 32'h12345678;
    #2;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_accept: got %b want 01", req_ready); end
    tick;
    req_valid[0] = 1'b0;
    #2;
    total++; if ({psel, penable} !== 2'b10) begin bad++; $display("FAIL wr_setup: got psel/penable=%b want 10", {psel, penable}); end
    total++; if ({paddr, pwrite, pwdata} !== {32'h10, 1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_bus: got addr=%h wr=%b data=%h", paddr, pwrite, pwdata); end
    tick; #2;
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL wr_access: got psel/penable=%b want 11", {psel, penable}); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_early_rsp: got %b want 00", rsp_valid); end
    tick; #2;
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid); end
    total++; if ({rsp_rdata, rsp_slverr, rsp_timeout} !== '0) begin bad++; $display("FAIL wr_rsp_fields: got rdata=%h err=%b to=%b want 0", rsp_rdata, rsp_slverr, rsp_timeout); end
    total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL wr_idle: got psel/penable=%b want 00", {psel, penable}); end
    tick; #2;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_read_wait;
    int en_cnt = 0;
    bit got = 1'b0;
    tick;
    set_req(1, 1'b1, 32'h24, 1'b0, 32'h0);
    s_waits = 2; s_rdata = 32'hA5A50001; s_err = 1'b0;
    #2;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_accept: got %b want 10", req_ready); end
    for (int k = 0; k < 20 && !got; k++) begin
      tick;
      req_valid[1] = 1'b0;
      #2;
      if (penable) begin
        en_cnt++;
        total++; if (paddr !== 32'h24) begin bad++; $display("FAIL rd_paddr_stable: got %h want 00000024", paddr); end
      end
      if (rsp_valid !== '0) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL rd_no_rsp: got no response want one within 20 cycles"); end
    total++; if (en_cnt !== 3) begin bad++; $display("FAIL rd_penable_cycles: got %0d want 3", en_cnt); end
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid); end
    total++; if (rsp_rdata !== 32'hA5A50001) begin bad++; $display("FAIL rd_rdata: got %h want a5a50001", rsp_rdata); end
  endtask

  task automatic test_back_to_back;
    int gq[4];
    int gc[4];
    int nacc = 0;
    s_waits = 0; s_err = 1'b0; s_rdata = $urandom;
    tick;
    set_req(0, 1'b1, $urandom, 1'b1, $urandom);
    set_req(1, 1'b1, $urandom, 1'b0, $urandom);
    for (int k = 0; k < 40 && nacc < 4; k++) begin
      #2;
      if (req_ready !== '0) begin
        gq[nacc] = req_ready[1] ? 1 : 0;
        gc[nacc] = k;
        nacc++;
      end
      tick;
    end
    req_valid = '0;
    total++; if (nacc !== 4) begin bad++; $display("FAIL b2b_accepts: got %0d want 4", nacc); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (gq[i] !== (i % 2)) begin bad++; $display("FAIL b2b_grant%0d: got %0d want %0d", i, gq[i], i % 2); end
      end
      total++; if (gc[1] - gc[0] !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", gc[1] - gc[0]); end
      total++; if (gc[2] - gc[0] !== 6) begin bad++; $display("FAIL b2b_req0_period: got %0d want 6", gc[2] - gc[0]); end
      total++; if (gc[3] - gc[1] !== 6) begin bad++; $display("FAIL b2b_req1_period: got %0d want 6", gc[3] - gc[1]); end
    end
    repeat (4) tick;
  endtask

  task automatic test_slverr;
    bit got = 1'b0;
    tick;
    set_req(0, 1'b1, $urandom, 1'b1, $urandom);
    s_waits = 0; s_err = 1'b1; s_rdata = 32'hCAFEF00D;
    #2;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL err_accept: got %b want 01", req_ready); end
    for (int k = 0; k < 10 && !got; k++) begin
      tick;
      req_valid[0] = 1'b0;
      #2;
      if (rsp_valid !== '0) got = 1'b1;
    end
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL err_rsp_valid: got %b want 01", rsp_valid); end
    total++; if ({rsp_slverr, rsp_timeout} !== 2'b10) begin bad++; $display("FAIL err_flags: got err/to=%b want 10", {rsp_slverr, rsp_timeout}); end
    total++; if (rsp_rdata !== '0) begin bad++; $display("FAIL err_rdata: got %h want 0", rsp_rdata); end
    s_err = 1'b0;
  endtask

  task automatic test_timeout;
    int acc = 0;
    bit got = 1'b0;
    tick;
    set_req(1, 1'b1, 32'h40, 1'b0, 32'h0);
    s_waits = 1000; s_rdata = 32'hFFFF0000; s_err = 1'b0;
    #2;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL to_accept: got %b want 10", req_ready); end
    for (int k = 0; k < 40 && !got; k++) begin
      tick;
      req_valid[1] = 1'b0;
      #2;
      if (psel && penable) acc++;
      if (rsp_valid !== '0) got = 1'b1;
    end
    total++; if (acc !== TIMEOUT_CYC) begin bad++; $display("FAIL to_access_cycles: got %0d want %0d", acc, TIMEOUT_CYC); end
    total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL to_rsp_valid: got %b want 10", rsp_valid); end
    total++; if ({rsp_slverr, rsp_timeout} !== 2'b11) begin bad++; $display("FAIL to_flags: got err/to=%b want 11", {rsp_slverr, rsp_timeout}); end
    total++; if (rsp_rdata !== '0) begin bad++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
    s_waits = 0;
    tick; #2;
    total++; if ({psel, penable, rsp_valid} !== 4'b0000) begin bad++; $display("FAIL to_back_idle: got psel/penable/rsp_valid=%b want 0000", {psel, penable, rsp_valid}); end
  endtask

  task automatic test_reset_mid;
    bit got = 1'b0;
    tick;
    set_req(1, 1'b1, 32'h80, 1'b0, 32'h0);
    s_waits = 1000;
    #2;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rst_accept: got %b want 10", req_ready); end
    tick; req_valid[1] = 1'b0;
    tick; #2;
    total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL rst_in_access: got psel/penable=%b want 11", {psel, penable}); end
    aresetn = 1'b0;
    #1;
    total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL rst_async_drop: got psel/penable=%b want 00", {psel, penable}); end
    s_waits = 0;
    set_req(0, 1'b1, 32'h100, 1'b1, 32'h55AA55AA);
    set_req(1, 1'b1, 32'h200, 1'b0, 32'h0);
    @(posedge aclk); #1;
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL rst_no_rsp: got %b want 00", rsp_valid); end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
    tick;
    req_valid = '0;
    #2;
    total++; if ({psel, paddr} !== {1'b1, 32'h100}) begin bad++; $display("FAIL rst_new_setup: got psel=%b addr=%h want 1/00000100", psel, paddr); end
    for (int k = 0; k < 10 && !got; k++) begin
      tick; #2;
      if (rsp_valid !== '0) got = 1'b1;
    end
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rst_rsp_owner: got %b want 01", rsp_valid); end
  endtask

  task automatic test_random(input int ncyc);
    logic [NUM_REQ-1:0] rv;
    logic [ADDR_W-1:0]  ra[NUM_REQ];
    logic               rw[NUM_REQ];
    logic [DATA_W-1:0]  rd[NUM_REQ];
    bit                 outst[NUM_REQ];
    int                 m_last, free_at, rsp_cyc, acc_cyc, g, w, a, rsp_owner;
    logic [NUM_REQ-1:0] e_ready, e_vec;
    logic [DATA_W-1:0]  e_rdata, c_wdata;
    logic [ADDR_W-1:0]  c_addr;
    logic               e_err, e_to, c_wr;

    req_valid = '0;
    rv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      outst[i] = 1'b0; ra[i] = '0; rw[i] = 1'b0; rd[i] = '0;
    end
    tick;
    aresetn = 1'b0;
    tick;
    @(negedge aclk);
    aresetn = 1'b1;
    m_last = NUM_REQ - 1; free_at = 0; rsp_cyc = -1; acc_cyc = -10; rsp_owner = 0;
    e_vec = '0; e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
    c_addr = '0; c_wr = 1'b0; c_wdata = '0;

    for (int n = 0; n < ncyc; n++) begin
      tick;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!outst[i]) begin
          if (!rv[i]) begin
            if ($urandom_range(2) == 0) begin
              rv[i] = 1'b1; ra[i] = $urandom; rw[i] = 1'($urandom_range(1)); rd[i] = $urandom;
            end
          end else if ($urandom_range(9) == 0) begin
            rv[i] = 1'b0;
          end
        end
        set_req(i, rv[i], ra[i], rw[i], rd[i]);
      end
      #2;

      total++;
      if (n == rsp_cyc) begin
        if (rsp_valid !== e_vec) begin bad++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", n, rsp_valid, e_vec); end
        total++;
        if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {e_rdata, e_err, e_to}) begin
          bad++; $display("FAIL rnd_rsp_fields@%0d: got rdata=%h err=%b to=%b want %h/%b/%b", n, rsp_rdata, rsp_slverr, rsp_timeout, e_rdata, e_err, e_to);
        end
        outst[rsp_owner] = 1'b0;
      end else if (rsp_valid !== '0) begin
        bad++; $display("FAIL rnd_spurious_rsp@%0d: got %b want 0", n, rsp_valid);
      end

      total++;
      if (n > acc_cyc && n < rsp_cyc) begin
        if ({psel, penable} !== {1'b1, (n >= acc_cyc + 2)} || paddr !== c_addr || pwrite !== c_wr || pwdata !== c_wdata) begin
          bad++; $display("FAIL rnd_bus@%0d: got sel=%b en=%b a=%h w=%b d=%h want en=%b a=%h w=%b d=%h",
                          n, psel, penable, paddr, pwrite, pwdata, (n >= acc_cyc + 2), c_addr, c_wr, c_wdata);
        end
      end else if ({psel, penable} !== 2'b00) begin
        bad++; $display("FAIL rnd_bus_idle@%0d: got psel/penable=%b want 00", n, {psel, penable});
      end

      e_ready = '0;
      g = -1;
      if (n >= free_at) begin
        g = rr_pick(rv, m_last);
        if (g >= 0) e_ready[g] = 1'b1;
      end
      total++;
      if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_req_ready@%0d: got %b want %b", n, req_ready, e_ready); end

      if (g >= 0) begin
        m_last    = g;
        acc_cyc   = n;
        w         = int'($urandom_range(TIMEOUT_CYC + 4));
        s_waits   = w;
        s_rdata   = $urandom;
        s_err     = ($urandom_range(3) == 0);
        a         = (w < TIMEOUT_CYC) ? w + 1 : TIMEOUT_CYC;
        rsp_cyc   = n + 2 + a;
        free_at   = rsp_cyc;
        rsp_owner = g;
        e_vec     = '0;
        e_vec[g]  = 1'b1;
        e_to      = (w >= TIMEOUT_CYC);
        e_rdata   = (e_to || rw[g]) ? '0 : s_rdata;
        e_err     = e_to | s_err;
        c_addr    = ra[g];
        c_wr      = rw[g];
        c_wdata   = rd[g];
        outst[g]  = 1'b1;
        rv[g]     = 1'b0;
      end
    end
    req_valid = '0;
    repeat (TIMEOUT_CYC + 6) tick;
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_read_wait;
    test_back_to_back;
    test_slverr;
    test_timeout;
    test_reset_mid;
    test_random(1500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port among NUM_REQ internal requesters using round-robin arbitration. Sequences the APB IDLE/SETUP/ACCESS protocol and returns the response to the granted requester. Terminates hung transfers with a wait-state timeout. Sits between the bridge's request sources and the APB interface signals psel/penable/paddr/pwrite/pwdata/prdata/pready/pslverr.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, max ACCESS cycles without pready before forced termination; 0 disables the timeout

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_write  in  NUM_REQ  1=write, 0=read
req_wdata  in  NUM_REQ*DATA_W  flattened write data
rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_slverr  out  1  error (pslverr or timeout)
rsp_timeout  out  1  transfer ended by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: single clock aclk. Reset aresetn is asynchronous and active-low. All state and outputs are registered except req_ready.
- Reset values:
  - state=IDLE; psel, penable, pwrite, paddr, pwdata = 0.
  - rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Timeout counter = 0.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid: the arbiter picks g, the first set bit searching from (last_grant+1) mod NUM_REQ with wrap-around.
  - req_ready[g]=1 combinationally in that cycle.
  - Register addr/write/wdata of g into paddr/pwrite/pwdata; set psel=1, last_grant=g; go to SETUP.
  - req_ready is 0 in all other states.
- SETUP: psel=1, penable=0 for exactly one cycle; set penable=1; go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable from SETUP.
  - pready=1: capture rsp_rdata = pwrite ? 0 : prdata; rsp_slverr=pslverr; rsp_timeout=0; rsp_valid[g]=1 for the next cycle. Clear psel/penable; go to IDLE.
  - pready=0: increment the counter. When TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with pready still 0, end as if ready: rsp_rdata=0, rsp_slverr=1, rsp_timeout=1.
  - The counter clears on entry to SETUP.
- pslverr and prdata are sampled only in ACCESS with pready=1.
- Latency with zero wait states: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3. Each wait state adds one cycle.
- rsp_valid and a new accept may coincide in the same IDLE cycle; both are legal.
- rsp fields other than rsp_valid hold their value until the next response.
- Requester contract: hold req_valid and payload stable until req_ready. At most one outstanding request per requester. A requester deasserting req_valid before grant is allowed.
- paddr/pwdata hold their last values in IDLE.
- Reset asserted mid-transfer: psel/penable drop immediately, the in-flight response is discarded, no rsp_valid, arbitration restarts at requester 0.

Decomposition:
- Package apb_arb_pkg holds the state enum (IDLE, SETUP, ACCESS) and the default widths.
- Sub-module rr_arbiter (parameter NUM_REQ): inputs req vector and last_grant; outputs one-hot grant and index.

Test Plan:
- Req0 write addr 0x10, data 0xDEADBEEF, pready=1 in the first ACCESS -> psel at cycle 1, penable at cycle 2, rsp_valid=01 at cycle 3, rsp_slverr=0, rsp_rdata=0.
- Req1 read addr 0x24, pready low for 2 ACCESS cycles, prdata=0xA5A50001 -> penable high 3 cycles, paddr stable, rsp_valid=10, rsp_rdata=0xA5A50001.
- Both req_valid held high with back-to-back requests -> grants 0,1,0,1; each requester gets one transfer per 6 cycles.
- Write with pready=1 and pslverr=1 -> rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYC=16, pready never asserted -> exactly 16 ACCESS cycles, then rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, return to IDLE.
- aresetn low during ACCESS for req1 -> psel=penable=0 asynchronously, no rsp_valid; after release with both valid, requester 0 is granted first.
